// File: rtl/key_conditioner.sv
// Push-button and switch conditioner: synchronizes KEY_N/SW, debounces the key with a
// power-on lockout, and emits registered press/release/long-press pulses plus a switch snapshot.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned SW_WIDTH        = 3
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                KEY_N,
    input  logic [SW_WIDTH-1:0] SW,
    output logic                PRESS_PULSE,
    output logic                RELEASE_PULSE,
    output logic                LONG_PULSE,
    output logic                KEY_LEVEL,
    output logic [SW_WIDTH-1:0] SW_CAPT,
    output logic [7:0]          PRESS_COUNT
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        LOCKOUT,
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic                key_meta_q, key_s_q;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_s_q;

    state_e              state_q, state_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic                long_done_q, long_done_d;
    logic                press_d, release_d, long_d;

    logic                press_ev_q, release_ev_q, long_ev_q;
    logic [SW_WIDTH-1:0] sw_hold_q;

    logic                press_q, release_q, long_q, level_q;
    logic [SW_WIDTH-1:0] sw_capt_q;
    logic [7:0]          count_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            key_meta_q <= KEY_N;
            key_s_q    <= key_meta_q;
            sw_meta_q  <= SW;
            sw_s_q     <= sw_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        unique case (state_q)
            LOCKOUT: begin
                if (!key_s_q) begin
                    dcnt_d = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d = RELEASED;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            RELEASED: begin
                if (!key_s_q) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s_q) begin
                    state_d = RELEASED;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d     = PRESSED;
                    dcnt_d      = '0;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                    press_d     = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (key_s_q) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (!long_done_q) begin
                    // hcnt parks at its last value; long_done blocks a second pulse
                    if (hcnt_q == H_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!key_s_q) begin
                    state_d = PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d   = RELEASED;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = LOCKOUT;
                dcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= LOCKOUT;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            long_done_q  <= 1'b0;
            press_ev_q   <= 1'b0;
            release_ev_q <= 1'b0;
            long_ev_q    <= 1'b0;
            sw_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            hcnt_q       <= hcnt_d;
            long_done_q  <= long_done_d;
            press_ev_q   <= press_d;
            release_ev_q <= release_d;
            long_ev_q    <= long_d;
            if (press_d) begin
                sw_hold_q <= sw_s_q;
            end
        end
    end

    // Output stage lags the FSM by one edge so level and pulses line up in the same cycle
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            level_q   <= 1'b0;
            sw_capt_q <= '0;
            count_q   <= '0;
        end else begin
            press_q   <= press_ev_q;
            release_q <= release_ev_q;
            long_q    <= long_ev_q;
            level_q   <= (state_q == PRESSED) || (state_q == RELEASE_WAIT);
            if (press_ev_q) begin
                sw_capt_q <= sw_hold_q;
                count_q   <= count_q + 8'd1;
            end
        end
    end

    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign LONG_PULSE    = long_q;
    assign KEY_LEVEL     = level_q;
    assign SW_CAPT       = sw_capt_q;
    assign PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner; a run-length debounce model predicts
// each pulse and a negedge monitor matches DUT pulses against the expected-event queue.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int H = 16;

    logic       CLOCK_50;
    logic       RESET;
    logic       KEY_N;
    logic [2:0] SW;
    logic       PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, KEY_LEVEL;
    logic [2:0] SW_CAPT;
    logic [7:0] PRESS_COUNT;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .SW_WIDTH       (3)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .KEY_N        (KEY_N),
        .SW           (SW),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .LONG_PULSE   (LONG_PULSE),
        .KEY_LEVEL    (KEY_LEVEL),
        .SW_CAPT      (SW_CAPT),
        .PRESS_COUNT  (PRESS_COUNT)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        int kind;
        int due;
        int sw;
        int cnt;
        int lvl;
    } ev_t;

    localparam int K_PRESS = 1;
    localparam int K_REL   = 2;
    localparam int K_LONG  = 3;
    localparam int M_LOCK  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  n_press = 0, n_rel = 0, n_long = 0;
    int  last_press_cyc = 0, last_long_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: synchronized samples feed run-length counters; a level flips after
    // D+1 opposing samples (D ones to leave power-on lockout).
    int m_s1, m_s2, m_w1, m_w2, m_mode, m_run, m_hold, m_long_done, m_count, m_capt;

    task automatic push(input int kind, input int lvl);
        ev_t e;
        e.kind = kind;
        e.due  = cyc + 1;
        e.sw   = m_capt;
        e.cnt  = m_count;
        e.lvl  = lvl;
        exp_q.push_back(e);
    endtask

    initial begin
        int ks, sws;
        forever begin
            @(posedge CLOCK_50);
            cyc++;
            if (RESET === 1'b1) begin
                m_s1 = 1; m_s2 = 1; m_w1 = 0; m_w2 = 0;
                m_mode = M_LOCK; m_run = 0; m_hold = 0; m_long_done = 0;
                m_count = 0; m_capt = 0;
                exp_q.delete();
            end else begin
                ks  = m_s2;
                sws = m_w2;
                m_s2 = m_s1; m_s1 = int'(KEY_N);
                m_w2 = m_w1; m_w1 = int'(SW);
                case (m_mode)
                    M_LOCK: begin
                        m_run = (ks == 1) ? m_run + 1 : 0;
                        if (m_run == D) begin
                            m_mode = M_UP;
                            m_run  = 0;
                        end
                    end
                    M_UP: begin
                        m_run = (ks == 0) ? m_run + 1 : 0;
                        if (m_run == D + 1) begin
                            m_mode = M_DOWN; m_run = 0; m_hold = 0; m_long_done = 0;
                            m_count = (m_count + 1) % 256;
                            m_capt  = sws;
                            push(K_PRESS, 1);
                        end
                    end
                    default: begin
                        if (ks == 1) begin
                            m_run++;
                            if (m_run == D + 1) begin
                                m_mode = M_UP;
                                m_run  = 0;
                                push(K_REL, 0);
                            end
                        end else if (m_run > 0) begin
                            m_run = 0;
                        end else if (m_long_done == 0) begin
                            m_hold++;
                            if (m_hold == H) begin
                                m_long_done = 1;
                                push(K_LONG, 1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        int np, kind;
        ev_t e;
        forever begin
            @(negedge CLOCK_50);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d due at cycle %0d never seen, expected a pulse",
                         exp_q[0].kind, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            np = int'(PRESS_PULSE === 1'b1) + int'(RELEASE_PULSE === 1'b1) + int'(LONG_PULSE === 1'b1);
            if (np > 0) begin
                if (np > 1) chk("one_pulse_per_cycle", np, 1);
                kind = (PRESS_PULSE === 1'b1) ? K_PRESS : (RELEASE_PULSE === 1'b1) ? K_REL : K_LONG;
                if (kind == K_PRESS) begin n_press++; last_press_cyc = cyc; end
                if (kind == K_REL)   n_rel++;
                if (kind == K_LONG)  begin n_long++; last_long_cyc = cyc; end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind",  kind,        e.kind);
                    chk("event_cycle", cyc,         e.due);
                    chk("sw_capt",     SW_CAPT,     e.sw);
                    chk("press_count", PRESS_COUNT, e.cnt);
                    chk("key_level",   KEY_LEVEL,   e.lvl);
                end
            end
        end
    end

    task automatic drive(input logic k, input int unsigned n, input bit rnd_sw);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            KEY_N = k;
            if (rnd_sw) SW = 3'($urandom);
        end
    endtask

    task automatic do_reset(input int unsigned n);
        @(negedge CLOCK_50);
        RESET = 1'b1;
        repeat (n) @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_press"},   PRESS_PULSE,   0);
        chk({name, "_release"}, RELEASE_PULSE, 0);
        chk({name, "_long"},    LONG_PULSE,    0);
        chk({name, "_level"},   KEY_LEVEL,     0);
        chk({name, "_swcapt"},  SW_CAPT,       0);
        chk({name, "_count"},   PRESS_COUNT,   0);
    endtask

    initial begin
        int e0, p0, r0, l0, len;
        RESET = 1'b1;
        KEY_N = 1'b1;
        SW    = '0;
        repeat (3) @(negedge CLOCK_50);
        chk_zero("in_reset");
        RESET = 1'b0;
        @(negedge CLOCK_50);
        chk_zero("after_reset");

        // Clean press
        drive(1'b1, 8, 1'b0);
        @(negedge CLOCK_50);
        KEY_N = 1'b0;
        SW    = 3'b101;
        e0    = cyc + 1;
        p0    = n_press;
        drive(1'b0, 19, 1'b0);
        chk("clean_press_latency", last_press_cyc - e0, 7);
        chk("clean_press_once",    n_press - p0, 1);
        chk("clean_swcapt",        SW_CAPT, 5);
        chk("clean_count",         PRESS_COUNT, 1);
        chk("clean_level",         KEY_LEVEL, 1);
        drive(1'b1, 10, 1'b0);

        // Bounce rejection from RELEASED
        p0 = n_press + n_rel + n_long;
        drive(1'b0, 3, 1'b0);
        drive(1'b1, 1, 1'b0);
        drive(1'b0, 3, 1'b0);
        drive(1'b1, 10, 1'b0);
        chk("bounce_no_pulse", n_press + n_rel + n_long - p0, 0);
        chk("bounce_level",    KEY_LEVEL, 0);
        chk("bounce_count",    PRESS_COUNT, 2 - 1);

        // Press, then release with a glitch while SW toggles
        drive(1'b0, 10, 1'b0);
        p0 = n_press;
        r0 = n_rel;
        drive(1'b1, 2, 1'b1);
        drive(1'b0, 2, 1'b1);
        drive(1'b1, 10, 1'b1);
        chk("glitch_one_release", n_rel - r0, 1);
        chk("glitch_no_press",    n_press - p0, 0);
        chk("glitch_swcapt",      SW_CAPT, 5);

        // Long press
        @(negedge CLOCK_50);
        KEY_N = 1'b0;
        e0    = cyc + 1;
        l0    = n_long;
        drive(1'b0, 39, 1'b0);
        chk("long_press_latency", last_press_cyc - e0, 7);
        chk("long_offset",        last_long_cyc - last_press_cyc, H);
        chk("long_once",          n_long - l0, 1);
        r0 = n_rel;
        drive(1'b1, 10, 1'b0);
        chk("long_release", n_rel - r0, 1);

        // Reset mid-press with the key still held
        drive(1'b0, 10, 1'b0);
        p0 = n_press;
        @(negedge CLOCK_50);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        drive(1'b0, 20, 1'b0);
        chk_zero("held_reset");
        chk("held_reset_no_press", n_press - p0, 0);
        drive(1'b1, 8, 1'b0);
        drive(1'b0, 10, 1'b0);
        chk("after_held_reset_count", PRESS_COUNT, 1);
        drive(1'b1, 10, 1'b0);

        // Random key/switch activity
        for (int i = 0; i < 150; i++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 12);
            drive(1'($urandom), len, 1'b1);
        end
        drive(1'b1, 12, 1'b0);

        // PRESS_COUNT wrap
        do_reset(2);
        drive(1'b1, 8, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            drive(1'b0, 10, 1'b1);
            if (i == 255) chk("count_255", PRESS_COUNT, 255);
            if (i == 256) chk("count_wrap", PRESS_COUNT, 0);
            drive(1'b1, 10, 1'b1);
        end

        drive(1'b1, 20, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Upstream input stage for the ALU sequencing FSM. It turns the raw, bouncing, active-low push-button `KEY[0]` and the raw slide switches `SW` into clean single-cycle event pulses, plus a switch snapshot taken at the moment of each accepted press. The FSM then advances exactly once per physical click and reads operands or opcodes that stay stable for the whole step.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive stable samples required to accept a level change. Must be ≥2.
- `HOLD_CYCLES`, default 50_000_000 (1 s): cycles a press must be held before the long-press event. Must be > `DEBOUNCE_CYCLES`.
- `SW_WIDTH`, default 3: switch bus width.
- `CLOCK_50`  in  1: single clock, rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `KEY_N`  in  1: raw button, asynchronous, 0 = pressed.
- `SW`  in  SW_WIDTH: raw switches, asynchronous.
- `PRESS_PULSE`  out  1: one-cycle pulse per accepted press.
- `RELEASE_PULSE`  out  1: one-cycle pulse per accepted release.
- `LONG_PULSE`  out  1: one-cycle pulse, at most once per press.
- `KEY_LEVEL`  out  1: debounced level, 1 = pressed.
- `SW_CAPT`  out  SW_WIDTH: synchronized `SW`, captured on each accepted press.
- `PRESS_COUNT`  out  8: count of accepted presses, modulo 256.

## Operation
- **Synchronizers.** `KEY_N` and each `SW` bit pass through 2-flop synchronizers, giving `key_s` and `sw_s`. On reset, the key synchronizer flops load 1 (released) and the SW synchronizer flops load 0.
- **Counters.**
  - Debounce counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES)`. Cleared on every state change.
  - Hold counter `hcnt`, width `$clog2(HOLD_CYCLES)`. Cleared on entry to PRESSED from PRESS_WAIT. It saturates and does not wrap.
- **State machine** (state register reset value is LOCKOUT):
  - **LOCKOUT**
    - `key_s`=1: `dcnt++`. When `dcnt`==`DEBOUNCE_CYCLES`-1, go to RELEASED. No pulse.
    - `key_s`=0: `dcnt`←0.
    - Effect: a key held through reset never produces a press.
  - **RELEASED**
    - `key_s`=0: go to PRESS_WAIT.
  - **PRESS_WAIT**
    - `key_s`=1: back to RELEASED (bounce rejected, no pulse).
    - `key_s`=0 and `dcnt`==`DEBOUNCE_CYCLES`-1: go to PRESSED. On the same edge:
      - `PRESS_PULSE`←1
      - `SW_CAPT`←`sw_s`
      - `PRESS_COUNT`←`PRESS_COUNT`+1 (wraps 255→0)
    - Otherwise `dcnt++`.
  - **PRESSED**
    - `key_s`=1: go to RELEASE_WAIT.
    - `key_s`=0: `hcnt++`. When `hcnt`==`HOLD_CYCLES`-1, `LONG_PULSE`←1 on that edge only. `hcnt` then saturates, so no further long pulse this press.
  - **RELEASE_WAIT**
    - `key_s`=0: back to PRESSED. `hcnt` retains its value; no press pulse.
    - `key_s`=1 and `dcnt`==`DEBOUNCE_CYCLES`-1: go to RELEASED, `RELEASE_PULSE`←1.
    - Otherwise `dcnt++`.
- **`KEY_LEVEL`** is registered: 1 exactly while the state is PRESSED or RELEASE_WAIT.
- **Output registers.** All outputs are registered. Each pulse output is 0 in every cycle it is not explicitly set.
- **`SW_CAPT`** changes only on an accepted press. `SW` activity at any other time has no effect on it.

## Timing
- **Reset values.** All outputs are 0 during reset and in the first cycle after `RESET` falls. `SW_CAPT`=0 and `PRESS_COUNT`=0.
- **Reset precedence.** `RESET` sampled high overrides every other condition, including mid-press and mid-pulse.
- **Press latency.** Let E0 be the first rising edge sampling `KEY_N`=0, with the key held from then on. `PRESS_PULSE` is high for the one cycle following edge E0+`DEBOUNCE_CYCLES`+3. This is 2 edges of synchronizer, 1 edge for RELEASED→PRESS_WAIT, and `DEBOUNCE_CYCLES` edges in PRESS_WAIT.
- **Release latency.** Measured from the first edge sampling `KEY_N`=1, release latency is the same as press latency.
- **Long-press timing.** `LONG_PULSE` is high in the cycle that is `HOLD_CYCLES` cycles after the `PRESS_PULSE` cycle, provided `key_s` stays 0 throughout.
- **Minimum event spacing.** Any two pulses of any kind are separated by at least `DEBOUNCE_CYCLES` cycles.
- **Simultaneous pulses.** A long pulse and a release pulse are never asserted in the same cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=16, `SW_WIDTH`=3.
- **Clean press.** Reset 3 cycles. Keep `KEY_N`=1 for 8 cycles, then drive `SW`=3'b101 and `KEY_N`=0 for 20 cycles.
  - `PRESS_PULSE` is high exactly 1 cycle, following edge E0+7.
  - `SW_CAPT`=5, `PRESS_COUNT`=1, `KEY_LEVEL`=1.
  - No other pulses.
- **Bounce rejection.** From RELEASED, drive `KEY_N` as 0×3, 1×1, 0×3, 1×10 cycles.
  - No pulses, `KEY_LEVEL` stays 0, `PRESS_COUNT` unchanged.
- **Release with glitch.** After a press, drive `KEY_N` as 1×2, 0×2, 1×10.
  - Exactly one `RELEASE_PULSE`, none before 4 stable synchronized high samples, no extra `PRESS_PULSE`.
  - `SW` toggling during this window leaves `SW_CAPT`=5.
- **Long press.** Hold `KEY_N`=0 for 40 cycles.
  - One `PRESS_PULSE`, then one `LONG_PULSE` exactly 16 cycles later, then nothing further.
  - Releasing yields one `RELEASE_PULSE`.
- **Reset mid-press.** While pressed, assert `RESET` for 2 cycles with `KEY_N` held at 0 for 20 more cycles.
  - All outputs 0, with no `PRESS_PULSE`.
  - Then drive `KEY_N`=1 for 8 cycles followed by a press: a `PRESS_PULSE` occurs, and `PRESS_COUNT`=1.
- **Counter wrap.** Perform 256 clean press/release cycles.
  - `PRESS_COUNT` reads 255 after the 255th press and 0 after the 256th.
